// File: rtl/updown_monitor.sv
// Checks a paired up/down counter stream for consistency, tracking lock, errors and wraps.
// Optional UPDOWN_MONITOR_STICKY_EN latches err_sticky on the first mismatch.
module updown_monitor #(
    parameter int unsigned LOCK_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] up_count,
    input  logic [3:0] down_count,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] wrap_count,
    output logic       err_sticky
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STAT_W   = 8;
    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_LEN);

    typedef enum logic {UNSYNC, TRACK} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    exp_up_q, exp_up_d;
    logic [CNT_W-1:0]    exp_down_q, exp_down_d;
    logic [CNT_W-1:0]    streak_q, streak_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [STAT_W-1:0]   err_count_q, err_count_d;
    logic [STAT_W-1:0]   wrap_count_q, wrap_count_d;
    logic                match_c;

    assign match_c = (up_count == exp_up_q) && (down_count == exp_down_q);

    // Expectations always re-derive from the current sample: sync, match and mismatch alike.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        exp_up_d     = up_count + CNT_W'(1);
        exp_down_d   = (up_count == CNT_W'(12)) ? down_count - CNT_W'(1) : down_count;

        case (state_q)
            UNSYNC: begin
                state_d = TRACK;
            end
            TRACK: begin
                if (match_c) begin
                    streak_d = (streak_q < LOCK_TGT) ? streak_q + CNT_W'(1) : streak_q;
                    locked_d = (streak_d == LOCK_TGT);
                    if (up_count == CNT_W'(0)) begin
                        wrap_count_d = wrap_count_q + STAT_W'(1);
                    end
                end else begin
                    err_d       = 1'b1;
                    streak_d    = '0;
                    locked_d    = 1'b0;
                    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + STAT_W'(1);
                end
            end
            default: begin
                state_d = UNSYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= UNSYNC;
            exp_up_q     <= '0;
            exp_down_q   <= '1;
            streak_q     <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            exp_up_q     <= exp_up_d;
            exp_down_q   <= exp_down_d;
            streak_q     <= streak_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

`ifdef UPDOWN_MONITOR_STICKY_EN
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_sticky_d = err_sticky_q | err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule
